// File: rtl/led_scan_decoder.sv
// Tracks a two-LED "scanner" bar on an 8-bit bus, locks onto a bouncing sweep,
// and reports position, direction, end-point reversals and sequence violations.
module led_scan_decoder #(
  parameter int unsigned LOCK_STEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_in,
  input  logic        sample_en,
  output logic [3:0]  pos,
  output logic        dir,
  output logic        locked,
  output logic        err,
  output logic [15:0] sweep_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

  state_t     state, state_nxt;
  logic [3:0] step_cnt, step_nxt;
  logic [3:0] pos_nxt;
  logic       dir_nxt;
  logic       err_nxt;
  logic       sweep_inc;

  logic       legal;
  logic [3:0] dec_pos;
  logic [3:0] exp_pos;
  logic       arrive_dir;
  logic       adjacent;
  logic       at_end;

  // Pattern decode: one LED at each end, two adjacent LEDs in between.
  always_comb begin
    legal   = 1'b1;
    dec_pos = 4'd0;
    unique case (led_in)
      8'h01:   dec_pos = 4'd0;
      8'h03:   dec_pos = 4'd1;
      8'h06:   dec_pos = 4'd2;
      8'h0C:   dec_pos = 4'd3;
      8'h18:   dec_pos = 4'd4;
      8'h30:   dec_pos = 4'd5;
      8'h60:   dec_pos = 4'd6;
      8'hC0:   dec_pos = 4'd7;
      8'h80:   dec_pos = 4'd8;
      default: legal   = 1'b0;
    endcase
  end

  // dir describes the next expected move, so it flips on arrival at an end.
  always_comb begin
    if (pos == 4'd8)      exp_pos = 4'd7;
    else if (pos == 4'd0) exp_pos = 4'd1;
    else if (dir)         exp_pos = pos - 4'd1;
    else                  exp_pos = pos + 4'd1;
    arrive_dir = (dec_pos == 4'd8) || ((dec_pos != 4'd0) && (dec_pos < pos));
    adjacent   = (dec_pos == pos + 4'd1) || (dec_pos + 4'd1 == pos);
    at_end     = (dec_pos == 4'd0) || (dec_pos == 4'd8);
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    pos_nxt   = pos;
    dir_nxt   = dir;
    err_nxt   = 1'b0;
    sweep_inc = 1'b0;

    if (sample_en) begin
      if (legal) pos_nxt = dec_pos;
      unique case (state)
        SEARCH: begin
          if (legal) begin
            step_nxt  = 4'd0;
            state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!legal) begin
            state_nxt = SEARCH;
          end else if ((step_cnt == 4'd0) ? adjacent : (dec_pos == exp_pos)) begin
            dir_nxt  = arrive_dir;
            step_nxt = step_cnt + 4'd1;
            if (step_cnt + 4'd1 == LOCK_N) begin
              state_nxt = LOCKED;
              sweep_inc = at_end;
            end
          end else begin
            step_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (legal && (dec_pos == exp_pos)) begin
            dir_nxt   = arrive_dir;
            sweep_inc = at_end;
          end else begin
            err_nxt   = 1'b1;
            step_nxt  = 4'd0;
            state_nxt = legal ? ACQUIRE : SEARCH;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      step_cnt  <= 4'd0;
      pos       <= 4'd0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      sweep_cnt <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
      pos      <= pos_nxt;
      dir      <= dir_nxt;
      locked   <= (state_nxt == LOCKED);
      err      <= err_nxt;
      if (sweep_inc && (sweep_cnt != 16'hFFFF)) sweep_cnt <= sweep_cnt + 16'd1;
      if (err_nxt && (err_cnt != 8'hFF))        err_cnt   <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed table-driven bench for led_scan_decoder (LOCK_STEPS = 4), plus
// hand-written sequences for idle hold, long sweeps and reset-while-locked.
module tb_led_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  led_in;
  logic        sample_en;
  logic [3:0]  pos;
  logic        dir;
  logic        locked;
  logic        err;
  logic [15:0] sweep_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  led_scan_decoder #(.LOCK_STEPS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .led_in    (led_in),
    .sample_en (sample_en),
    .pos       (pos),
    .dir       (dir),
    .locked    (locked),
    .err       (err),
    .sweep_cnt (sweep_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] led;
    int         pos;
    int         dir;
    int         lck;
    int         err;
    int         sw;
    int         ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the active edge.
  task automatic apply(input vec_t v, input string tag);
    rst       = v.rst;
    sample_en = v.en;
    led_in    = v.led;
    @(posedge clk);
    #1;
    check({tag, ".pos"},       int'(pos),       v.pos);
    check({tag, ".dir"},       int'(dir),       v.dir);
    check({tag, ".locked"},    int'(locked),    v.lck);
    check({tag, ".err"},       int'(err),       v.err);
    check({tag, ".sweep_cnt"}, int'(sweep_cnt), v.sw);
    check({tag, ".err_cnt"},   int'(err_cnt),   v.ec);
  endtask

  function automatic logic [7:0] pat(input int p);
    case (p)
      0: pat = 8'h01;  1: pat = 8'h03;  2: pat = 8'h06;
      3: pat = 8'h0C;  4: pat = 8'h18;  5: pat = 8'h30;
      6: pat = 8'h60;  7: pat = 8'hC0;  8: pat = 8'h80;
      default: pat = 8'h00;
    endcase
  endfunction

  initial begin
    vec_t v;
    int p, d, sw, nxt, guard;

    rst = 1'b1; sample_en = 1'b0; led_in = 8'h00;

    //            rst   en    led    pos dir lck err sw ec
    vecs.push_back('{1'b1, 1'b0, 8'h00, 0, 0, 0, 0, 0, 0});
    // Acquire from 0, lock one cycle after 0x18.
    vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h18, 4, 0, 1, 0, 0, 0});
    // Full bounce: up to 8, down to 0.
    vecs.push_back('{1'b0, 1'b1, 8'h30, 5, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h60, 6, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 7, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 7, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h60, 6, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h30, 5, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h18, 4, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, 3, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 2, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 1, 1, 0, 1, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 0, 1, 0, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 0, 1, 0, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 2, 0, 1, 0, 2, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, 3, 0, 1, 0, 2, 0});
    // Jump 3 -> 5 while locked: err, drop to ACQUIRE at 5; then idle holds.
    vecs.push_back('{1'b0, 1'b1, 8'h30, 5, 0, 0, 1, 2, 1});
    vecs.push_back('{1'b0, 1'b0, 8'hFF, 5, 0, 0, 0, 2, 1});
    // Relock from 5; passing 8 during ACQUIRE does not count a sweep.
    vecs.push_back('{1'b0, 1'b1, 8'h60, 6, 0, 0, 0, 2, 1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 7, 0, 0, 0, 2, 1});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8, 1, 0, 0, 2, 1});
    vecs.push_back('{1'b0, 1'b1, 8'hC0, 7, 1, 1, 0, 2, 1});
    // Illegal while locked: err, SEARCH, pos held; illegal in SEARCH: silent.
    vecs.push_back('{1'b0, 1'b1, 8'h55, 7, 1, 0, 1, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h55, 7, 1, 0, 0, 2, 2});
    // Restart in ACQUIRE on a non-adjacent sample, then lock landing on 0.
    vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 1, 0, 0, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h18, 4, 1, 0, 0, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, 3, 1, 0, 0, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 2, 1, 0, 0, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 1, 0, 0, 2, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 0, 1, 0, 3, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 0, 1, 0, 3, 2});
    // Repeated value while locked is a violation.
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 0, 0, 1, 3, 3});
    // Reset overrides a valid sample.
    vecs.push_back('{1'b1, 1'b1, 8'h06, 0, 0, 0, 0, 0, 0});
    // Illegal sample in ACQUIRE falls back to SEARCH without err.
    vecs.push_back('{1'b0, 1'b1, 8'h01, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h18, 4, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h30, 5, 0, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 1'b1, 8'h60, 6, 0, 1, 0, 0, 0});

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Idle with random bus contents: nothing moves, err stays low.
    for (int i = 0; i < 10; i++) begin
      v = '{1'b0, 1'b0, 8'($urandom), 6, 0, 1, 0, 0, 0};
      apply(v, $sformatf("idle%0d", i));
    end
    v = '{1'b0, 1'b1, 8'hC0, 7, 0, 1, 0, 0, 0};
    apply(v, "after_idle");

    // Walk the bounce until seven end-point reversals have been seen.
    p = 7; d = 0; sw = 0; guard = 0;
    while (sw < 7 && guard < 100) begin
      if (p == 8)      nxt = 7;
      else if (p == 0) nxt = 1;
      else             nxt = d ? p - 1 : p + 1;
      if (nxt == 8) d = 1;
      if (nxt == 0) d = 0;
      if (nxt == 0 || nxt == 8) sw++;
      p = nxt;
      v = '{1'b0, 1'b1, pat(p), p, d, 1, 0, sw, 0};
      apply(v, $sformatf("walk%0d", guard));
      guard++;
    end
    check("walk_guard", int'(guard < 100), 1);
    check("walk_sweep7", int'(sweep_cnt), 7);

    // Reset while locked clears everything; relock needs four fresh steps.
    v = '{1'b1, 1'b1, 8'h01, 0, 0, 0, 0, 0, 0};
    apply(v, "rst_locked");
    v = '{1'b0, 1'b1, 8'h01, 0, 0, 0, 0, 0, 0}; apply(v, "relock0");
    v = '{1'b0, 1'b1, 8'h03, 1, 0, 0, 0, 0, 0}; apply(v, "relock1");
    v = '{1'b0, 1'b1, 8'h06, 2, 0, 0, 0, 0, 0}; apply(v, "relock2");
    v = '{1'b0, 1'b1, 8'h0C, 3, 0, 0, 0, 0, 0}; apply(v, "relock3");
    v = '{1'b0, 1'b1, 8'h18, 4, 0, 1, 0, 0, 0}; apply(v, "relock4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
